// File: rtl/cdf_pkg.sv
// Shared definitions for the CDF read-out path: FSM encoding and word/bin geometry.
package cdf_pkg;

  localparam int BINS_PER_WORD = 8;
  localparam int BIN_WIDTH     = 16;
  localparam int WORD_WIDTH    = 128;
  localparam int ADDR_WIDTH    = 16;
  localparam int LANE_WIDTH    = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } cdf_state_t;

endpackage

// File: rtl/cdf_word_unpack.sv
// Selects one 16-bit CDF bin lane out of a 128-bit scratch-memory word.
module cdf_word_unpack
  import cdf_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [LANE_WIDTH-1:0] lane,
  output logic [BIN_WIDTH-1:0]  value
);

  logic [BIN_WIDTH-1:0] lanes [BINS_PER_WORD];

  for (genvar gi = 0; gi < BINS_PER_WORD; gi++) begin : g_lane
    assign lanes[gi] = word[gi*BIN_WIDTH +: BIN_WIDTH];
  end

  assign value = lanes[lane];

endmodule

// File: rtl/cdf_reader.sv
// Streams 256 CDF bins out of scratch memory with valid/ready handshake and
// records the first nonzero bin value seen in the pass.
module cdf_reader
  import cdf_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] CDF_BASE_ADDR = 16'd0,
  parameter int                    NUM_WORDS     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cdf_start_in,
  output logic [ADDR_WIDTH-1:0] ReadAddress1,
  input  logic [WORD_WIDTH-1:0] scratchmem_input1,
  output logic [BIN_WIDTH-1:0]  cdf_value_out,
  output logic [7:0]            cdf_bin_out,
  output logic                  cdf_valid_out,
  input  logic                  cdf_ready_in,
  output logic [BIN_WIDTH-1:0]  cdf_min_out,
  output logic                  cdf_min_valid,
  output logic                  cdf_read_done
);

  localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);

  cdf_state_t            state_reg, state_next;
  logic                  start_pend_reg;
  logic [15:0]           word_cnt_reg;
  logic [LANE_WIDTH-1:0] lane_reg;
  logic [WORD_WIDTH-1:0] word_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [BIN_WIDTH-1:0]  min_reg;
  logic                  min_found_reg;
  logic                  min_valid_reg;

  logic                  transfer;
  logic                  start_accept;
  logic [15:0]           word_inc;
  logic [BIN_WIDTH-1:0]  lane_value;

  cdf_word_unpack u_unpack (
    .word  (word_reg),
    .lane  (lane_reg),
    .value (lane_value)
  );

  assign word_inc = word_cnt_reg + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    transfer      = 1'b0;
    start_accept  = 1'b0;
    cdf_valid_out = 1'b0;
    cdf_read_done = 1'b0;
    case (state_reg)
      IDLE: begin
        // The start is captured one cycle before ISSUE so the read issue lines up with the latency contract.
        start_accept = cdf_start_in && !start_pend_reg;
        if (start_pend_reg) state_next = ISSUE;
      end
      ISSUE: state_next = WAIT;
      WAIT:  state_next = EMIT;
      EMIT: begin
        cdf_valid_out = 1'b1;
        if (cdf_ready_in) begin
          transfer = 1'b1;
          if (lane_reg == 3'd7)
            state_next = (word_cnt_reg < LAST_WORD) ? ISSUE : DONE;
        end
      end
      DONE: begin
        cdf_read_done = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_pend_reg <= 1'b0;
      word_cnt_reg   <= '0;
      lane_reg       <= '0;
      word_reg       <= '0;
      addr_reg       <= CDF_BASE_ADDR;
      min_reg        <= '0;
      min_found_reg  <= 1'b0;
      min_valid_reg  <= 1'b0;
    end else begin
      start_pend_reg <= start_accept;
      if (start_accept) begin
        word_cnt_reg  <= '0;
        min_reg       <= '0;
        min_found_reg <= 1'b0;
        min_valid_reg <= 1'b0;
      end
      if (state_reg == IDLE && start_pend_reg)
        addr_reg <= CDF_BASE_ADDR + word_cnt_reg;
      if (state_reg == WAIT) begin
        word_reg <= scratchmem_input1;
        lane_reg <= '0;
      end
      if (transfer) begin
        lane_reg <= lane_reg + 3'd1;
        if (lane_reg == 3'd7 && word_cnt_reg < LAST_WORD) begin
          word_cnt_reg <= word_inc;
          addr_reg     <= CDF_BASE_ADDR + word_inc;
        end
        if (!min_found_reg && lane_value != '0) begin
          min_reg       <= lane_value;
          min_found_reg <= 1'b1;
        end
      end
      if (state_reg == EMIT && state_next == DONE)
        min_valid_reg <= 1'b1;
    end
  end

  assign ReadAddress1  = addr_reg;
  assign cdf_value_out = lane_value;
  assign cdf_bin_out   = {word_cnt_reg[4:0], lane_reg};
  assign cdf_min_out   = min_reg;
  assign cdf_min_valid = min_valid_reg;

endmodule

// File: tb/tb_cdf_reader.sv
// Scoreboard bench for cdf_reader: stimulus queues expected bins, a negedge
// monitor pops and compares every transfer and every done pulse.
module tb_cdf_reader;

  localparam logic [15:0] BASE = 16'hFFF0;  // forces the address adder to wrap mid-pass
  localparam int          NW   = 32;

  logic         clk;
  logic         reset;
  logic         cdf_start_in;
  logic [15:0]  ReadAddress1;
  logic [127:0] scratchmem_input1;
  logic [15:0]  cdf_value_out;
  logic [7:0]   cdf_bin_out;
  logic         cdf_valid_out;
  logic         cdf_ready_in;
  logic [15:0]  cdf_min_out;
  logic         cdf_min_valid;
  logic         cdf_read_done;

  cdf_reader #(.CDF_BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
    .clk               (clk),
    .reset             (reset),
    .cdf_start_in      (cdf_start_in),
    .ReadAddress1      (ReadAddress1),
    .scratchmem_input1 (scratchmem_input1),
    .cdf_value_out     (cdf_value_out),
    .cdf_bin_out       (cdf_bin_out),
    .cdf_valid_out     (cdf_valid_out),
    .cdf_ready_in      (cdf_ready_in),
    .cdf_min_out       (cdf_min_out),
    .cdf_min_valid     (cdf_min_valid),
    .cdf_read_done     (cdf_read_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] words [NW];
  logic [15:0]  word_off;
  assign word_off = ReadAddress1 - BASE;
  always @(posedge clk) scratchmem_input1 <= words[word_off[4:0]];

  typedef struct packed {
    logic [7:0]  bin;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] min_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_count = 0;
  int          cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: transfers, hold stability and done pulses.
  bit          hold_pend = 1'b0;
  logic [7:0]  hold_bin;
  logic [15:0] hold_val;
  exp_t        e;
  always @(negedge clk) begin
    if (hold_pend && !reset) begin
      check("hold_valid", 32'(cdf_valid_out), 32'd1);
      check("hold_bin", 32'(cdf_bin_out), 32'(hold_bin));
      check("hold_value", 32'(cdf_value_out), 32'(hold_val));
    end
    hold_pend = cdf_valid_out && !cdf_ready_in && !reset;
    hold_bin  = cdf_bin_out;
    hold_val  = cdf_value_out;
    if (cdf_valid_out && cdf_ready_in && !reset) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_transfer: got bin %0d value %0h, expected no transfer", cdf_bin_out, cdf_value_out);
      end else begin
        e = exp_q.pop_front();
        $display("xfer bin=%0d value=%0h", cdf_bin_out, cdf_value_out);
        check("bin", 32'(cdf_bin_out), 32'(e.bin));
        check("value", 32'(cdf_value_out), 32'(e.val));
      end
    end
    if (cdf_read_done) begin
      done_count++;
      $display("done min=%0h min_valid=%0b", cdf_min_out, cdf_min_valid);
      check("min_valid_at_done", 32'(cdf_min_valid), 32'd1);
      check("bins_left_at_done", 32'(exp_q.size()), 32'd0);
      if (min_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done pulse, expected none");
      end else begin
        check("min_at_done", 32'(cdf_min_out), 32'(min_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    words[0] = {16'd20, 16'd12, 16'd9, 16'd9, 16'd5, 16'd3, 16'd0, 16'd0};
    for (int w = 1; w < NW; w++)
      for (int l = 0; l < 8; l++)
        words[w][16*l +: 16] = 16'(100 * w + l);
    words[NW-1][127:112] = 16'hFFFF;
  endtask

  task automatic load_zero();
    for (int w = 0; w < NW; w++) words[w] = '0;
  endtask

  task automatic push_bins(input int nbins);
    exp_t x;
    for (int i = 0; i < nbins; i++) begin
      x.bin = 8'(i);
      x.val = words[i/8][16*(i%8) +: 16];
      exp_q.push_back(x);
    end
  endtask

  task automatic pulse_start();
    cdf_start_in = 1'b1;
    tick();
    cdf_start_in = 1'b0;
    cyc = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(ReadAddress1), 32'(BASE));
    check({tag, "_value"}, 32'(cdf_value_out), 32'd0);
    check({tag, "_bin"}, 32'(cdf_bin_out), 32'd0);
    check({tag, "_valid"}, 32'(cdf_valid_out), 32'd0);
    check({tag, "_min"}, 32'(cdf_min_out), 32'd0);
    check({tag, "_min_valid"}, 32'(cdf_min_valid), 32'd0);
    check({tag, "_done"}, 32'(cdf_read_done), 32'd0);
  endtask

  task automatic run_to_done(input int limit, input int req_cycles);
    while (!cdf_read_done && cyc < limit) begin
      tick();
      cyc++;
    end
    check("done_seen", 32'(cdf_read_done), 32'd1);
    if (req_cycles >= 0) check("done_cycle", 32'(cyc), 32'(req_cycles));
  endtask

  bit [3:0] ready_pat;

  initial begin
    reset        = 1'b1;
    cdf_start_in = 1'b0;
    cdf_ready_in = 1'b0;
    load_zero();
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Pass 1: ramp data, ready held high, stray start during EMIT.
    load_ramp();
    push_bins(256);
    min_q.push_back(16'd3);
    cdf_ready_in = 1'b1;
    pulse_start();
    check("min_valid_after_start", 32'(cdf_min_valid), 32'd0);
    tick(); cyc++;
    check("first_addr", 32'(ReadAddress1), 32'(BASE));
    check("valid_n1", 32'(cdf_valid_out), 32'd0);
    tick(); cyc++;
    check("valid_n2", 32'(cdf_valid_out), 32'd0);
    tick(); cyc++;
    check("valid_n3", 32'(cdf_valid_out), 32'd1);
    check("first_bin", 32'(cdf_bin_out), 32'd0);
    tick(); cyc++;
    cdf_start_in = 1'b1;
    tick(); cyc++;
    cdf_start_in = 1'b0;
    run_to_done(400, 321);
    tick();
    check("done_one_cycle", 32'(cdf_read_done), 32'd0);
    check("min_valid_held", 32'(cdf_min_valid), 32'd1);
    check("min_held", 32'(cdf_min_out), 32'd3);
    repeat (5) tick();
    check("done_count_pass1", 32'(done_count), 32'd1);
    check("idle_valid", 32'(cdf_valid_out), 32'd0);

    // Pass 2: all-zero CDF with ready pattern 1,0,0,1.
    load_zero();
    push_bins(256);
    min_q.push_back(16'd0);
    ready_pat = 4'b1001;
    pulse_start();
    check("min_valid_cleared", 32'(cdf_min_valid), 32'd0);
    check("min_cleared", 32'(cdf_min_out), 32'd0);
    while (!cdf_read_done && cyc < 2000) begin
      cdf_ready_in = ready_pat[cyc % 4];
      tick();
      cyc++;
    end
    check("done_seen_zero", 32'(cdf_read_done), 32'd1);
    cdf_ready_in = 1'b1;
    tick();
    check("zero_min", 32'(cdf_min_out), 32'd0);
    check("zero_min_valid", 32'(cdf_min_valid), 32'd1);
    check("done_count_pass2", 32'(done_count), 32'd2);

    // Pass 3: reset while bin 100 is presented, then a clean restart.
    load_ramp();
    push_bins(100);
    pulse_start();
    while (!(cdf_valid_out && cdf_bin_out == 8'd100) && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("reached_bin100", 32'(cdf_bin_out), 32'd100);
    cdf_ready_in = 1'b0;
    reset        = 1'b1;
    tick();
    check_reset_outputs("midpass_reset");
    check("queue_after_reset", 32'(exp_q.size()), 32'd0);
    reset        = 1'b0;
    cdf_ready_in = 1'b1;
    tick();
    push_bins(256);
    min_q.push_back(16'd3);
    pulse_start();
    run_to_done(400, 321);
    repeat (3) tick();
    check("done_count_pass3", 32'(done_count), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdf_reader.md
CDF_READER -- requirements
Module: cdf_reader

Interface
REQ-001 Parameter CDF_BASE_ADDR, default 16'd0: scratch-memory word address of CDF bin 0.
REQ-002 Parameter NUM_WORDS, default 32: number of 128-bit CDF words (8 bins each, 256 bins total).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cdf_start_in  input  1  one-cycle pulse; starts a CDF read-out pass.
REQ-006 ReadAddress1  output  16  scratch-memory read address.
REQ-007 scratchmem_input1  input  128  scratch-memory read data, valid the cycle after ReadAddress1 is presented.
REQ-008 cdf_value_out  output  16  current CDF bin value.
REQ-009 cdf_bin_out  output  8  index of current bin.
REQ-010 cdf_valid_out  output  1  cdf_value_out/cdf_bin_out valid.
REQ-011 cdf_ready_in  input  1  downstream accepts; transfer occurs when valid and ready are both high at a rising edge.
REQ-012 cdf_min_out  output  16  first nonzero CDF value, in bin order.
REQ-013 cdf_min_valid  output  1  cdf_min_out final for this pass.
REQ-014 cdf_read_done  output  1  one-cycle pulse at end of pass.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, EMIT, DONE.
REQ-016 IDLE -> ISSUE when cdf_start_in=1; cdf_start_in is ignored in every other state.
REQ-017 ISSUE: drives ReadAddress1 = CDF_BASE_ADDR + word counter; goes to WAIT next cycle.
REQ-018 WAIT: latches scratchmem_input1 into a 128-bit word register; lane counter cleared; goes to EMIT.
REQ-019 Lane mapping: lane L (0..7) = word bits [16L+15:16L]; bin index = word*8 + L, truncated to 8 bits.
REQ-020 EMIT: cdf_valid_out=1; on each transfer the lane counter advances.
REQ-021 Transfer of lane 7 with word counter < NUM_WORDS-1 -> word counter +1, go to ISSUE; with the last word -> DONE.
REQ-022 cdf_ready_in low holds cdf_value_out, cdf_bin_out and cdf_valid_out stable; no bin is dropped or repeated.
REQ-023 Latency: cdf_start_in sampled high at edge N -> cdf_valid_out high after edge N+3 (IDLE->ISSUE, ->WAIT, ->EMIT).
REQ-024 Per-word throughput: 8 transfers + 2 overhead cycles when cdf_ready_in is held high.
REQ-025 cdf_min tracking: the first transferred bin with nonzero value loads cdf_min_out; later bins leave it unchanged.
REQ-026 DONE: for one cycle, cdf_read_done=1 and cdf_min_valid set; then return to IDLE.
REQ-027 cdf_min_valid stays high until the next accepted cdf_start_in, which clears it and cdf_min_out.
REQ-028 All-zero CDF: cdf_min_out=0 and cdf_min_valid=1 at DONE.
REQ-029 ReadAddress1 holds its last value outside ISSUE; the address adder wraps modulo 2^16.

Reset
REQ-030 reset=1 forces IDLE from any state, including mid-pass, and clears counters and the word register.
REQ-031 Output values under reset: ReadAddress1=CDF_BASE_ADDR; cdf_value_out=0; cdf_bin_out=0; cdf_valid_out=0; cdf_min_out=0; cdf_min_valid=0; cdf_read_done=0.
REQ-032 reset takes priority over cdf_start_in in the same cycle.

Structure
REQ-033 Shared cdf package contents: FSM state encoding, BINS_PER_WORD=8, BIN_WIDTH=16, word width 128, address width 16.
REQ-034 Sub-module cdf_word_unpack: lane mux selecting a 16-bit lane by lane counter; all other logic is flat in cdf_reader.

Verification
REQ-035 Word0 lanes = 0,0,3,5,9,9,12,20; ready=1; NUM_WORDS=1 -> bins 0..7 emitted on consecutive cycles; cdf_min_out=3; done pulse one cycle after bin 7.
REQ-036 Start at edge N -> ReadAddress1=CDF_BASE_ADDR after edge N+1; first valid after edge N+3.
REQ-037 ready toggled 1,0,0,1 during EMIT -> outputs frozen while ready=0; bin sequence contiguous, no duplicates.
REQ-038 All words zero, NUM_WORDS=32 -> 256 transfers, last cdf_bin_out=255; cdf_min_out=0, cdf_min_valid=1.
REQ-039 reset asserted at bin 100 -> next cycle IDLE with all REQ-031 output values; a new start restarts at bin 0.
REQ-040 cdf_start_in pulsed during EMIT -> ignored; pass completes normally with exactly one done pulse.
